// File: rtl/presc_pkg.sv
// presc_pkg: shared constants and the channel mode encoding for the
// multi-channel clock-enable prescaler.
package presc_pkg;

    // Default channel count, counter width and reset divisor
    // (200000 gives a 500 Hz CE from a 100 MHz CLK).
    localparam int DFLT_NUM_CH = 4;
    localparam int DFLT_CNT_W  = 18;
    localparam int DFLT_DIV    = 200000;

    // Per-channel run mode.
    typedef enum logic {
        MODE_CONT    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

endpackage

// File: rtl/ce_presc_chan.sv
// ce_presc_chan: one prescaler channel. Holds the counter, the programmable
// divisor and the one-shot done flag, and emits a registered one-cycle CE
// pulse every max(div,1) qualified edges. 'adv' qualifies which edges count;
// it is tied high for free-running channels and driven by the previous
// channel's CE when cascading.
module ce_presc_chan
    import presc_pkg::*;
#(
    parameter int CNT_W   = DFLT_CNT_W,
    parameter int DEF_DIV = DFLT_DIV
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             en,
    input  logic             mode,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    input  logic             adv,
    output logic             ce_o,
    output logic             active
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;
    logic [CNT_W-1:0] last_cnt;
    logic             done_q;
    logic             done_d;
    logic             ce_d;
    mode_e            chan_mode;

    assign chan_mode = mode_e'(mode);

    // Terminal count is effective_div-1; divisors 0 and 1 both terminate at 0,
    // so the channel fires on every qualified edge.
    assign last_cnt = (div_q > CNT_W'(1)) ? div_q - CNT_W'(1) : '0;

    // Next-state logic, priority: SYNC > LOAD > EN low > done > count.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q;
        div_d  = div_q;
        done_d = done_q;
        ce_d   = 1'b0;

        // A LOAD always updates the divisor, even when SYNC wins the restart.
        if (load) begin
            div_d = load_div;
        end

        if (sync || load || !en) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (done_q) begin
            cnt_d = '0;
        end else if (adv) begin
            if (cnt_q == last_cnt) begin
                cnt_d  = '0;
                ce_d   = 1'b1;
                done_d = (chan_mode == MODE_ONESHOT);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            cnt_q  <= '0;
            div_q  <= CNT_W'(DEF_DIV);
            done_q <= 1'b0;
            ce_o   <= 1'b0;
            active <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            done_q <= done_d;
            ce_o   <= ce_d;
            active <= en & ~done_d;
        end
    end

endmodule

// File: rtl/ce_prescaler_multi.sv
// ce_prescaler_multi: NUM_CH independent clock-enable generators with
// runtime-loadable divisors, per-channel enable and one-shot mode, and a
// global SYNC restart. Decodes LOAD/LOAD_CH and flags out-of-range loads.
// Build option: define PRESC_CASCADE_EN to chain channel k>0 onto the CE of
// channel k-1 (period = product of divisors); otherwise channels run freely.
module ce_prescaler_multi
    import presc_pkg::*;
#(
    parameter int NUM_CH  = DFLT_NUM_CH,
    parameter int CNT_W   = DFLT_CNT_W,
    parameter int DEF_DIV = DFLT_DIV,
    parameter int CH_W    = 2
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic [NUM_CH-1:0] EN,
    input  logic [NUM_CH-1:0] MODE,
    input  logic              SYNC,
    input  logic              LOAD,
    input  logic [CH_W-1:0]   LOAD_CH,
    input  logic [CNT_W-1:0]  LOAD_DIV,
    output logic [NUM_CH-1:0] CE_O,
    output logic [NUM_CH-1:0] ACTIVE,
    output logic              LOAD_ERR
);

    logic [NUM_CH-1:0] load_sel;
    logic [NUM_CH-1:0] adv;
    logic              ch_invalid;

    // LOAD_CH may address more slots than exist when NUM_CH is not a power of two.
    assign ch_invalid = (32'(LOAD_CH) >= 32'(NUM_CH));

    // Out-of-range loads are dropped and reported with a one-cycle pulse.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            LOAD_ERR <= 1'b0;
        end else begin
            LOAD_ERR <= LOAD & ch_invalid;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load_sel[i] = LOAD && (32'(LOAD_CH) == 32'(i));

`ifdef PRESC_CASCADE_EN
        if (i == 0) begin : g_root
            assign adv[i] = 1'b1;
        end else begin : g_link
            assign adv[i] = CE_O[i-1];
        end
`else
        assign adv[i] = 1'b1;
`endif

        ce_presc_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .CLK      (CLK),
            .CLR_N    (CLR_N),
            .en       (EN[i]),
            .mode     (MODE[i]),
            .sync     (SYNC),
            .load     (load_sel[i]),
            .load_div (LOAD_DIV),
            .adv      (adv[i]),
            .ce_o     (CE_O[i]),
            .active   (ACTIVE[i])
        );
    end

endmodule

// File: tb/tb_ce_prescaler_multi.sv
// tb_ce_prescaler_multi: drives a 4-channel and a 3-channel prescaler from
// the same stimulus and compares both against a counting reference model
// every cycle, plus directed vectors and hand-written corner sequences.
module tb_ce_prescaler_multi;

    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 5;

    logic       CLK   = 1'b0;
    logic       CLR_N = 1'b0;
    logic [3:0] en;
    logic [3:0] mode;
    logic       sync;
    logic       load;
    logic [1:0] load_ch;
    logic [7:0] load_div;

    logic [3:0] ce4;
    logic [3:0] act4;
    logic       err4;
    logic [2:0] ce3;
    logic [2:0] act3;
    logic       err3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ce_prescaler_multi #(
        .NUM_CH(4), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .CH_W(2)
    ) dut4 (
        .CLK(CLK), .CLR_N(CLR_N), .EN(en), .MODE(mode), .SYNC(sync),
        .LOAD(load), .LOAD_CH(load_ch), .LOAD_DIV(load_div),
        .CE_O(ce4), .ACTIVE(act4), .LOAD_ERR(err4)
    );

    ce_prescaler_multi #(
        .NUM_CH(3), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .CH_W(2)
    ) dut3 (
        .CLK(CLK), .CLR_N(CLR_N), .EN(en[2:0]), .MODE(mode[2:0]), .SYNC(sync),
        .LOAD(load), .LOAD_CH(load_ch), .LOAD_DIV(load_div),
        .CE_O(ce3), .ACTIVE(act3), .LOAD_ERR(err3)
    );

    // ---------------- reference model ----------------
    // Each channel counts qualified edges since its last restart; a CE falls
    // on every multiple of max(div,1).
    int         m_ticks [2][4];
    bit         m_done  [2][4];
    int         m_div   [2][4];
    logic [3:0] m_ce    [2];
    logic [3:0] m_act   [2];
    logic       m_err   [2];
    int         m_nch   [2] = '{4, 3};

    function automatic void model_reset();
        for (int j = 0; j < 2; j++) begin
            for (int c = 0; c < 4; c++) begin
                m_ticks[j][c] = 0;
                m_done[j][c]  = 1'b0;
                m_div[j][c]   = DEF_DIV;
            end
            m_ce[j]  = '0;
            m_act[j] = '0;
            m_err[j] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int j = 0; j < 2; j++) begin
            logic [3:0] prev_ce;
            prev_ce = m_ce[j];
            for (int c = 0; c < m_nch[j]; c++) begin
                bit ld;
                bit adv;
                int eff;
                adv = 1'b1;
`ifdef PRESC_CASCADE_EN
                if (c > 0) adv = prev_ce[c-1];
`endif
                ld = load && (int'(load_ch) == c);
                if (ld) m_div[j][c] = int'(load_div);
                m_ce[j][c] = 1'b0;
                if (sync || ld || !en[c]) begin
                    m_ticks[j][c] = 0;
                    m_done[j][c]  = 1'b0;
                end else if (!m_done[j][c] && adv) begin
                    eff = (m_div[j][c] == 0) ? 1 : m_div[j][c];
                    m_ticks[j][c] = m_ticks[j][c] + 1;
                    if (m_ticks[j][c] % eff == 0) begin
                        m_ce[j][c] = 1'b1;
                        if (mode[c]) m_done[j][c] = 1'b1;
                    end
                end
                m_act[j][c] = en[c] && !m_done[j][c];
            end
            m_err[j] = load && (int'(load_ch) >= m_nch[j]);
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_ce4",  32'(ce4),  32'(m_ce[0]));
        check("model_act4", 32'(act4), 32'(m_act[0]));
        check("model_err4", 32'(err4), 32'(m_err[0]));
        check("model_ce3",  32'(ce3),  32'(m_ce[1]));
        check("model_act3", 32'(act3), 32'(m_act[1]));
        check("model_err3", 32'(err3), 32'(m_err[1]));
    endtask

    // Inputs are set just after an edge; the model advances, then outputs are
    // sampled 1 time unit after the next rising edge.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic [3:0] en;
        logic       load;
        logic [1:0] ch;
        logic [7:0] div;
        logic [3:0] exp_ce;
        logic [3:0] exp_act;
    } vec_t;

    vec_t vecs [20];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p[$];
        int exp_first;
        int exp_per;

        en = '0; mode = '0; sync = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ce4",  32'(ce4),  0);
        check("rst_act4", 32'(act4), 0);
        check("rst_err4", 32'(err4), 0);
        check("rst_ce3",  32'(ce3),  0);
        check("rst_act3", 32'(act3), 0);
        check("rst_err3", 32'(err3), 0);
        CLR_N = 1'b1;
        tick();
        tick();

        // A: default divisor 5, channel 0 continuous.
        en = 4'b0001;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("A_ce",  32'(ce4),  (i % 5 == 0) ? 32'h1 : 32'h0);
            check("A_act", 32'(act4), 32'h1);
        end

        // B: loads mid-stream and boundary divisors on channel 0.
        vecs[0]  = '{4'b0001, 1'b1, 2'd0, 8'd3, 4'b0000, 4'b0001};
        vecs[1]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0001};
        vecs[2]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0001};
        vecs[3]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001};
        vecs[4]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0001};
        vecs[5]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0001};
        vecs[6]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001};
        vecs[7]  = '{4'b0001, 1'b1, 2'd0, 8'd0, 4'b0000, 4'b0001};
        vecs[8]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001};
        vecs[9]  = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001};
        vecs[10] = '{4'b0001, 1'b1, 2'd0, 8'd1, 4'b0000, 4'b0001};
        vecs[11] = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001};
        vecs[12] = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001};
        vecs[13] = '{4'b0001, 1'b1, 2'd0, 8'd5, 4'b0000, 4'b0001};
        vecs[14] = '{4'b0001, 1'b1, 2'd2, 8'd7, 4'b0000, 4'b0001};
        vecs[15] = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0001};
        vecs[16] = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0001};
        vecs[17] = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0001};
        vecs[18] = '{4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001};
        vecs[19] = '{4'b0000, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000};
        for (int i = 0; i < 20; i++) begin
            en = vecs[i].en; load = vecs[i].load;
            load_ch = vecs[i].ch; load_div = vecs[i].div;
            tick();
            check($sformatf("B%0d_ce", i),  32'(ce4),  32'(vecs[i].exp_ce));
            check($sformatf("B%0d_act", i), 32'(act4), 32'(vecs[i].exp_act));
            check($sformatf("B%0d_err", i), 32'(err4), 0);
        end
        load = 1'b0;

        // C: out-of-range load on the 3-channel build.
        en = '0; load = 1'b1; load_ch = 2'd3; load_div = 8'd1;
        tick();
        check("C_err3", 32'(err3), 1);
        check("C_err4", 32'(err4), 0);
        load = 1'b0;
        tick();
        check("C_err3_clear", 32'(err3), 0);
        en = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("C_ce3_div_kept", 32'(ce3), (i == 5) ? 32'h1 : 32'h0);
        end

        // D: one-shot on channel 0, SYNC re-arm, then asynchronous reset.
        en = '0;
        tick();
        mode = 4'b0001; en = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("D_os_ce",  32'(ce4),  (i == 5) ? 32'h1 : 32'h0);
            check("D_os_act", 32'(act4), (i < 5) ? 32'h1 : 32'h0);
        end
        sync = 1'b1;
        tick();
        check("D_sync_ce",  32'(ce4),  0);
        check("D_sync_act", 32'(act4), 1);
        sync = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("D_rearm_ce",  32'(ce4),  (i == 5) ? 32'h1 : 32'h0);
            check("D_rearm_act", 32'(act4), (i < 5) ? 32'h1 : 32'h0);
        end
        mode = '0; en = '0;
        tick();
        en = 4'b0001;
        for (int i = 1; i <= 5; i++) tick();
        check("D_pre_rst_ce", 32'(ce4), 1);
        #2;
        CLR_N = 1'b0;
        #1;
        check("D_arst_ce4",  32'(ce4),  0);
        check("D_arst_act4", 32'(act4), 0);
        check("D_arst_ce3",  32'(ce3),  0);
        check("D_arst_act3", 32'(act3), 0);
        model_reset();
        @(posedge CLK);
        #1;
        CLR_N = 1'b1;
        en = '0;
        tick();

        // E: channel 1 period with div0=2, div1=3.
        load = 1'b1; load_ch = 2'd0; load_div = 8'd2;
        tick();
        load_ch = 2'd1; load_div = 8'd3;
        tick();
        load = 1'b0; sync = 1'b1;
        tick();
        sync = 1'b0; en = 4'b0011;
`ifdef PRESC_CASCADE_EN
        exp_first = 7; exp_per = 6;
`else
        exp_first = 3; exp_per = 3;
`endif
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ce4[1] === 1'b1) p.push_back(i);
        end
        check("E_enough_pulses", 32'(p.size() >= 3), 1);
        if (p.size() >= 3) begin
            check("E_first", 32'(p[0]), 32'(exp_first));
            check("E_per1",  32'(p[1] - p[0]), 32'(exp_per));
            check("E_per2",  32'(p[2] - p[1]), 32'(exp_per));
        end

        // F: randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            sync     = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 5) == 0);
            load_ch  = 2'($urandom_range(0, 3));
            load_div = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) en   = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 4'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ce_prescaler_multi.md
Name: ce_prescaler_multi

Overview:
- Multi-channel clock-enable generator; each channel emits a one-cycle CE pulse at a runtime-programmable period.
- Per-channel enable, continuous or one-shot mode, and a global SYNC that phase-aligns all channels.
- Feeds LED refresh, PWM-step and debounce logic in the LED driver; all downstream logic runs on CLK and is qualified by CE_O.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 18, counter and divisor width in bits.
- DEF_DIV, 200000, divisor loaded at reset (500 Hz CE at 100 MHz CLK).
- CH_W, 2, width of LOAD_CH (must satisfy 2**CH_W >= NUM_CH).

Ports:
- CLK  in  1  system clock.
- CLR_N  in  1  asynchronous active-low reset.
- EN  in  NUM_CH  per-channel run enable, level-sensitive.
- MODE  in  NUM_CH  per-channel mode: 0 = continuous, 1 = one-shot.
- SYNC  in  1  one-cycle strobe; restarts all channels from zero.
- LOAD  in  1  one-cycle strobe; writes LOAD_DIV into channel LOAD_CH.
- LOAD_CH  in  CH_W  target channel index.
- LOAD_DIV  in  CNT_W  new divisor value.
- CE_O  out  NUM_CH  registered one-cycle clock-enable pulses.
- ACTIVE  out  NUM_CH  registered; 1 = channel counting (EN=1 and not one-shot-done).
- LOAD_ERR  out  1  registered one-cycle pulse when LOAD_CH >= NUM_CH.

Behaviour:
- Reset (CLR_N=0, asynchronous): cnt=0, div=DEF_DIV, done=0, CE_O=0, ACTIVE=0, LOAD_ERR=0 on all channels.
- Effective divisor: effective_div = max(div, 1). A div of 0 or 1 gives a CE on every enabled cycle.
- Per-channel priority, evaluated each rising edge: SYNC > LOAD (this channel) > EN=0 > done > count.
- SYNC: cnt=0, done=0, CE_O=0 on all channels. A LOAD in the same cycle still updates div, but the counter restart comes from SYNC.
- LOAD to a valid channel: div<=LOAD_DIV, cnt<=0, done<=0, CE_O<=0 that cycle. Other channels are unaffected.
- LOAD to an invalid channel (LOAD_CH >= NUM_CH): ignored; LOAD_ERR=1 for exactly one cycle.
- EN=0: cnt held at 0, CE_O=0, done cleared. Re-asserting EN restarts a full period.
- Counting (EN=1, done=0):
  - if cnt == effective_div-1: cnt<=0 and CE_O<=1;
  - else cnt<=cnt+1 and CE_O<=0.
  - First CE is asserted effective_div cycles after the first enabled edge; the period is exactly effective_div cycles.
- One-shot (MODE=1): on the edge that sets CE_O=1, also set done=1. The channel then holds cnt=0 and CE_O=0 until SYNC, a LOAD to that channel, or EN going low.
- MODE changes take effect on the next edge; done is not cleared by a MODE change.
- ACTIVE is registered as EN & ~done_next.
- Counter arithmetic is CNT_W-bit unsigned. cnt can never exceed effective_div-1, so no wrap is possible.

Optional Feature:
- Macro: PRESC_CASCADE_EN.
- Defined: channel 0 counts CLK edges. Channel k>0 advances only on edges where CE_O[k-1]==1, giving period = product of the cascaded divisors. SYNC, LOAD and EN rules are unchanged. A one-shot channel k stops feeding channel k+1 once done.
- Undefined: every channel counts CLK edges independently.

Decomposition:
- Package presc_pkg: default CNT_W, DEF_DIV and NUM_CH constants; a mode enum (MODE_CONT=0, MODE_ONESHOT=1).
- Sub-module ce_presc_chan: one channel holding cnt, div, done and CE/ACTIVE registers, with an advance-qualifier input. The top level instantiates NUM_CH copies, decodes LOAD/LOAD_CH, generates LOAD_ERR, and does the cascade wiring under the macro.

Test Plan (bench uses NUM_CH=4, CNT_W=8, DEF_DIV=5 unless stated):
- Reset then EN=4'b0001, MODE=0 -> CE_O[0] pulses at cycles 5, 10, 15 after EN; other CE_O bits stay 0; ACTIVE=4'b0001.
- LOAD ch1 with div=3 mid-count, EN=4'b0010 -> CE_O[1] low on the load edge, then pulses 3 cycles later and every 3 cycles after.
- Boundary divisors: LOAD div=0, then div=1 -> CE_O asserted every enabled cycle in both cases.
- LOAD_CH=... (NUM_CH=3 build, LOAD_CH=3) -> LOAD_ERR high for exactly 1 cycle; all divisors unchanged.
- One-shot: MODE[2]=1, EN[2]=1 -> exactly one CE_O[2] at cycle 5 and ACTIVE[2] drops. SYNC -> a second pulse 5 cycles later. Assert CLR_N=0 mid-count -> all outputs 0 immediately, with no clock edge needed.
- PRESC_CASCADE_EN defined, div0=2, div1=3, EN=4'b0011 -> CE_O[1] period 6 cycles. Undefined -> CE_O[1] period 3 cycles.
